// File: rtl/control_cmd_dispatch.sv
// Command dispatcher: decodes an opcode byte, hands the following byte stream and the
// framebuffer RAM bus to the readrow or readpixel engine, and aborts stalled commands.

package params_pkg;
  parameter int BYTES_PER_PIXEL = 3;
  parameter int PIXEL_HEIGHT    = 32;
  parameter int PIXEL_WIDTH     = 64;
endpackage

package calc_pkg;
  function automatic int num_row_address_bits(input int pixel_height);
    return (pixel_height <= 2) ? 1 : $clog2(pixel_height);
  endfunction

  function automatic int num_column_address_bits(input int pixel_width);
    return (pixel_width <= 2) ? 1 : $clog2(pixel_width);
  endfunction

  function automatic int num_pixelcolorselect_bits(input int bytes_per_pixel);
    return (bytes_per_pixel <= 2) ? 1 : $clog2(bytes_per_pixel);
  endfunction
endpackage

module control_cmd_dispatch #(
  parameter int BYTES_PER_PIXEL = params_pkg::BYTES_PER_PIXEL,
  parameter int PIXEL_HEIGHT    = params_pkg::PIXEL_HEIGHT,
  parameter int PIXEL_WIDTH     = params_pkg::PIXEL_WIDTH,
  parameter int TIMEOUT_CYCLES  = 4096,
  localparam int R = calc_pkg::num_row_address_bits(PIXEL_HEIGHT),
  localparam int C = calc_pkg::num_column_address_bits(PIXEL_WIDTH),
  localparam int P = calc_pkg::num_pixelcolorselect_bits(BYTES_PER_PIXEL),
  localparam int B = R + C + P + 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   data_in,
  input  logic         enable,
  output logic         rr_enable,
  input  logic         rr_done,
  input  logic [B-1:0] rr_ram_bus,
  output logic         px_enable,
  input  logic         px_done,
  input  logic [B-1:0] px_ram_bus,
  output logic [B-1:0] ram_bus,
  output logic         busy,
  output logic         cmd_error,
  output logic         timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] OP_ROW = 8'h4C;
  localparam logic [7:0] OP_PIX = 8'h50;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROW  = 2'd1,
    PIX  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cmd_error_q, cmd_error_d;
  logic          timeout_q, timeout_d;

  logic sel_row;
  logic sel_pix;
  logic active_done;

  assign sel_row     = (state_q == ROW);
  assign sel_pix     = (state_q == PIX);
  // Only the owning engine's done is honoured; the other one is ignored.
  assign active_done = (sel_row & rr_done) | (sel_pix & px_done);

  assign rr_enable = sel_row & enable;
  assign px_enable = sel_pix & enable;
  assign busy      = (state_q != IDLE);
  assign cmd_error = cmd_error_q;
  assign timeout   = timeout_q;

  // Per-bit AND-OR mux: the deselected engine's bus is gated to zero.
  for (genvar gi = 0; gi < B; gi++) begin : g_bus_mux
    assign ram_bus[gi] = (sel_row & rr_ram_bus[gi]) | (sel_pix & px_ram_bus[gi]);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_error_d = 1'b0;
    timeout_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable) begin
          if (data_in == OP_ROW) begin
            state_d = ROW;
          end else if (data_in == OP_PIX) begin
            state_d = PIX;
          end else begin
            cmd_error_d = 1'b1;
          end
        end
      end
      ROW, PIX: begin
        // Done has priority over both the strobe restart and the timeout abort.
        if (active_done) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (enable) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_error_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_error_q <= cmd_error_d;
      timeout_q   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_control_cmd_dispatch.sv
// Directed bench for control_cmd_dispatch: row, pixel, bad opcode, timeout, reset and
// back-to-back command scenarios with hand-computed expectations.

module tb_control_cmd_dispatch;

  localparam int B = 23;  // 5 row + 6 column + 2 pixel-select + 10 with the default panel
  localparam logic [B-1:0] PX_BUS = 23'h2AAAA5;
  localparam logic [B-1:0] RR_BASE = 23'h0A5A00;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   data_in;
  logic         enable;
  logic         rr_enable;
  logic         rr_done;
  logic [B-1:0] rr_ram_bus;
  logic         px_enable;
  logic         px_done;
  logic [B-1:0] px_ram_bus;
  logic [B-1:0] ram_bus;
  logic         busy;
  logic         cmd_error;
  logic         timeout;

  int checks = 0;
  int errors = 0;
  int rr_pulses;
  int px_pulses;

  control_cmd_dispatch #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk       (clk),
    .reset     (rst),
    .data_in   (data_in),
    .enable    (enable),
    .rr_enable (rr_enable),
    .rr_done   (rr_done),
    .rr_ram_bus(rr_ram_bus),
    .px_enable (px_enable),
    .px_done   (px_done),
    .px_ram_bus(px_ram_bus),
    .ram_bus   (ram_bus),
    .busy      (busy),
    .cmd_error (cmd_error),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are changed and comb outputs sampled 1-2 time units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    enable  = 1'b0;
    data_in = 8'h00;
    rr_done = 1'b0;
    px_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst        = 1'b1;
    rr_ram_bus = RR_BASE;
    px_ram_bus = PX_BUS;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    enable = 1'b1;
    data_in = 8'h20;
    rst = 1'b1;  // strobe under reset must not raise cmd_error
    tick();
    rst = 1'b0;
    idle_inputs();
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_cmd_error", 32'(cmd_error), 32'd0);
    check("reset_timeout", 32'(timeout), 32'd0);
    check("reset_ram_bus", 32'(ram_bus), 32'd0);
    $display("transaction reset: busy=%0b ram_bus=%0h", busy, ram_bus);

    // Row command: opcode then 16 payload bytes, done on the last one.
    tick();
    enable = 1'b1;
    data_in = 8'h4C;
    #1;
    check("row_opcode_rr_en", 32'(rr_enable), 32'd0);
    check("row_opcode_ram_bus", 32'(ram_bus), 32'd0);
    tick();
    enable = 1'b0;
    #1;
    check("row_busy_rise", 32'(busy), 32'd1);
    rr_pulses = 0;
    px_pulses = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      enable     = 1'b1;
      data_in    = 8'(i);
      rr_ram_bus = RR_BASE + B'(i);
      rr_done    = (i == 15);
      #1;
      rr_pulses += int'(rr_enable);
      px_pulses += int'(px_enable);
      check("row_ram_bus", 32'(ram_bus), 32'(RR_BASE + B'(i)));
    end
    check("row_rr_pulses", 32'(rr_pulses), 32'd16);
    check("row_px_pulses", 32'(px_pulses), 32'd0);
    // Back-to-back: 0x50 in the first IDLE cycle after rr_done.
    tick();
    idle_inputs();
    enable = 1'b1;
    data_in = 8'h50;
    #1;
    check("row_busy_fall", 32'(busy), 32'd0);
    check("b2b_rr_en", 32'(rr_enable), 32'd0);
    check("b2b_px_en", 32'(px_enable), 32'd0);
    $display("transaction row: rr_pulses=%0d px_pulses=%0d", rr_pulses, px_pulses);

    // Pixel command: rr_done pulses must be ignored while in PIX.
    tick();
    idle_inputs();
    #1;
    check("b2b_busy", 32'(busy), 32'd1);
    check("pix_ram_bus", 32'(ram_bus), 32'(PX_BUS));
    rr_pulses = 0;
    px_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      enable  = 1'b1;
      data_in = 8'(8'hA0 + i);
      rr_done = (i == 1);
      px_done = (i == 3);
      #1;
      rr_pulses += int'(rr_enable);
      px_pulses += int'(px_enable);
      check("pix_ram_bus_byte", 32'(ram_bus), 32'(PX_BUS));
      if (i == 2) check("pix_rr_done_ignored", 32'(busy), 32'd1);
    end
    check("pix_px_pulses", 32'(px_pulses), 32'd4);
    check("pix_rr_pulses", 32'(rr_pulses), 32'd0);
    tick();
    idle_inputs();
    #1;
    check("pix_busy_fall", 32'(busy), 32'd0);
    check("pix_idle_ram_bus", 32'(ram_bus), 32'd0);
    $display("transaction pixel: px_pulses=%0d rr_pulses=%0d", px_pulses, rr_pulses);

    // Bad opcode 'A'.
    tick();
    enable = 1'b1;
    data_in = 8'h41;
    #1;
    check("bad_rr_en", 32'(rr_enable), 32'd0);
    check("bad_px_en", 32'(px_enable), 32'd0);
    tick();
    idle_inputs();
    #1;
    check("bad_cmd_error", 32'(cmd_error), 32'd1);
    check("bad_busy", 32'(busy), 32'd0);
    tick();
    check("bad_cmd_error_clear", 32'(cmd_error), 32'd0);
    check("bad_busy_after", 32'(busy), 32'd0);
    $display("transaction bad_opcode: cmd_error=%0b busy=%0b", cmd_error, busy);

    // Timeout: enter ROW, no strobes; counter reaches 7 after seven further edges.
    for (int run = 0; run < 2; run++) begin
      tick();
      enable = 1'b1;
      data_in = 8'h4C;
      tick();  // ROW entry edge
      idle_inputs();
      for (int k = 1; k <= 7; k++) begin
        tick();
        check("to_busy_hold", 32'(busy), 32'd1);
        check("to_no_early", 32'(timeout), 32'd0);
      end
      rr_done = (run == 1);
      tick();
      idle_inputs();
      check("to_busy_fall", 32'(busy), 32'd0);
      check("to_pulse", 32'(timeout), (run == 0) ? 32'd1 : 32'd0);
      check("to_no_cmd_error", 32'(cmd_error), 32'd0);
      tick();
      check("to_pulse_end", 32'(timeout), 32'd0);
      $display("transaction timeout run=%0d: done_in_last_cycle=%0d", run, run);
    end

    // Reset mid-row after 5 payload bytes.
    tick();
    enable = 1'b1;
    data_in = 8'h4C;
    for (int i = 0; i < 5; i++) begin
      tick();
      enable     = 1'b1;
      data_in    = 8'(i);
      rr_ram_bus = RR_BASE + B'(i);
    end
    tick();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_ram_bus", 32'(ram_bus), 32'd0);
    check("rst_mid_timeout", 32'(timeout), 32'd0);
    check("rst_mid_cmd_error", 32'(cmd_error), 32'd0);
    tick();
    enable = 1'b1;
    data_in = 8'h50;
    #1;
    check("rst_op_px_en", 32'(px_enable), 32'd0);
    tick();
    idle_inputs();
    #1;
    check("rst_pix_busy", 32'(busy), 32'd1);
    check("rst_pix_ram_bus", 32'(ram_bus), 32'(PX_BUS));
    px_done = 1'b1;
    tick();
    idle_inputs();
    check("rst_pix_done", 32'(busy), 32'd0);
    check("rst_pix_no_timeout", 32'(timeout), 32'd0);
    $display("transaction reset_mid_row: busy=%0b", busy);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
